seg7_scan_ctrl: RTL

//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one decoder.

---
 rtl/seg7_scan_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Brief    : Time-multiplexed scan controller for common-anode 7-segment
//             digits sharing one decoder. Blanking gap between digits, host
//             load handshake applied only at frame boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIG = 4,
    parameter int DIG_W   = 4,
    parameter int DWELL   = 50000,
    parameter int BLANK   = 500
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iEN,
    input  logic                     iLOAD,
    input  logic [NUM_DIG*DIG_W-1:0] iDATA,
    input  logic [NUM_DIG-1:0]       iDP,
    output logic                     oACK,
    output logic [DIG_W-1:0]         oDIG,
    output logic                     oDP_N,
    output logic [NUM_DIG-1:0]       oAN_N,
    output logic                     oFRAME
);

    localparam int c_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_DIG);
    localparam bit c_HAS_GAP = (BLANK > 0);

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    // With no gap the BLANK state is never entered, so this value is unused.
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    // State after a digit ends: gap if configured, else straight to the next digit.
    localparam state_t c_AFTER_DIGIT = c_HAS_GAP ? S_BLANK : S_SHOW;

    state_t                     r_state;
    logic [c_IDX_W-1:0]         r_idx;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [NUM_DIG*DIG_W-1:0]   r_disp;
    logic [NUM_DIG-1:0]         r_dp;
    logic [NUM_DIG*DIG_W-1:0]   r_sh_data;
    logic [NUM_DIG-1:0]         r_sh_dp;
    logic                       r_pend;
    logic                       r_ack;
    logic [DIG_W-1:0]           r_dig;
    logic                       r_dp_n;
    logic [NUM_DIG-1:0]         r_an_n;
    logic                       r_frame;

    state_t                     w_state_nxt;
    logic [c_IDX_W-1:0]         w_idx_nxt;
    logic [c_CNT_W-1:0]         w_cnt_nxt;
    logic [NUM_DIG*DIG_W-1:0]   w_disp_nxt;
    logic [NUM_DIG-1:0]         w_dp_nxt;
    logic [NUM_DIG*DIG_W-1:0]   w_sh_data_nxt;
    logic [NUM_DIG-1:0]         w_sh_dp_nxt;
    logic                       w_pend_nxt;
    logic                       w_ack_nxt;
    logic                       w_boundary;
    logic [DIG_W-1:0]           w_dig_nxt;
    logic                       w_dp_n_nxt;
    logic [NUM_DIG-1:0]         w_an_n_nxt;

    // Next-state, load handshake and next-output decode; outputs are then registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_disp_nxt    = r_disp;
        w_dp_nxt      = r_dp;
        w_sh_data_nxt = r_sh_data;
        w_sh_dp_nxt   = r_sh_dp;
        w_pend_nxt    = r_pend;
        w_ack_nxt     = 1'b0;

        // Last dwell cycle of the last digit while scanning continues.
        w_boundary = iEN && (r_state == S_SHOW) && (r_idx == c_IDX_LAST)
                     && (r_cnt == c_DWELL_LAST);

        // Scan sequencing
        if (!iEN) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = c_AFTER_DIGIT;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
                S_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = S_SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (r_cnt == c_DWELL_LAST) begin
                        w_state_nxt = c_AFTER_DIGIT;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : (r_idx + c_IDX_W'(1));
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Load handshake: a load coinciding with the boundary bypasses the shadow.
        if (w_boundary && iLOAD) begin
            w_disp_nxt = iDATA;
            w_dp_nxt   = iDP;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
        end else begin
            if (r_pend && ((r_state == S_IDLE) || w_boundary)) begin
                w_disp_nxt = r_sh_data;
                w_dp_nxt   = r_sh_dp;
                w_pend_nxt = 1'b0;
                w_ack_nxt  = 1'b1;
            end
            if (iLOAD) begin
                w_sh_data_nxt = iDATA;
                w_sh_dp_nxt   = iDP;
                w_pend_nxt    = 1'b1;
            end
        end

        // Outputs reflect the state being entered, using the display value after any apply.
        w_dig_nxt  = w_disp_nxt[w_idx_nxt*DIG_W +: DIG_W];
        w_an_n_nxt = '1;
        w_dp_n_nxt = 1'b1;
        if (w_state_nxt == S_SHOW) begin
            w_an_n_nxt = ~(NUM_DIG'(1) << w_idx_nxt);
            w_dp_n_nxt = ~w_dp_nxt[w_idx_nxt];
        end
    end

    // State, display/shadow registers and registered outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_disp    <= '0;
            r_dp      <= '0;
            r_sh_data <= '0;
            r_sh_dp   <= '0;
            r_pend    <= 1'b0;
            r_ack     <= 1'b0;
            r_dig     <= '0;
            r_dp_n    <= 1'b1;
            r_an_n    <= '1;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_disp    <= w_disp_nxt;
            r_dp      <= w_dp_nxt;
            r_sh_data <= w_sh_data_nxt;
            r_sh_dp   <= w_sh_dp_nxt;
            r_pend    <= w_pend_nxt;
            r_ack     <= w_ack_nxt;
            r_dig     <= w_dig_nxt;
            r_dp_n    <= w_dp_n_nxt;
            r_an_n    <= w_an_n_nxt;
            r_frame   <= w_boundary;
        end
    end

    assign oACK   = r_ack;
    assign oDIG   = r_dig;
    assign oDP_N  = r_dp_n;
    assign oAN_N  = r_an_n;
    assign oFRAME = r_frame;

endmodule
`default_nettype wire
